// File: rtl/systolic_feeder.sv
// Purpose: two-lane operand sequencer; streams len buffered operands per lane, drains FLUSH zero cycles, pulses o_done.
// Latency: first operand appears 1 cycle after start is sampled; o_busy lasts len + FLUSH + 1 cycles.
// Backpressure: none; the stream free-runs once accepted, and start/writes are dropped while busy.
//
// Ports:
//   i_clk, i_rstn                  clock (rising edge), asynchronous active-low reset
//   i_wr_en/lane/addr/data         operand buffer write port (honoured only while idle)
//   i_start, i_len                 start request and element count (1..DEPTH)
//   o_busy, o_valid, o_done        sequence status (all registered)
//   o_lane0, o_lane1               operands to skew stage in1 / in2
module systolic_feeder #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int FLUSH  = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_wr_en,
  input  logic                       i_wr_lane,
  input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_start,
  input  logic [$clog2(DEPTH):0]     i_len,
  output logic                       o_busy,
  output logic                       o_valid,
  output logic [DATA_W-1:0]          o_lane0,
  output logic [DATA_W-1:0]          o_lane1,
  output logic                       o_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [LW-1:0]       len_q, len_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic [DATA_W-1:0]   lane0_q, lane0_d;
  logic [DATA_W-1:0]   lane1_q, lane1_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   buf0_q [DEPTH];
  logic [DATA_W-1:0]   buf1_q [DEPTH];

  logic accept;
  logic last_elem;
  logic last_flush;
  logic wr_ok;

  assign accept     = (state_q == S_IDLE) && i_start &&
                      (i_len != '0) && (i_len <= LW'(DEPTH));
  assign last_elem  = (LW'(cnt_q) == (len_q - LW'(1)));
  assign last_flush = (int'(fcnt_q) == FLUSH - 1);
  // An accepted start wins over a write on the same edge.
  assign wr_ok      = i_wr_en && (state_q == S_IDLE) && !accept;

  // State, counters, registered outputs and operand buffers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      fcnt_q  <= '0;
      lane0_q <= '0;
      lane1_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf0_q[i] <= '0;
        buf1_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      fcnt_q  <= fcnt_d;
      lane0_q <= lane0_d;
      lane1_q <= lane1_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (wr_ok) begin
        if (i_wr_lane) buf1_q[i_wr_addr] <= i_wr_data;
        else           buf0_q[i_wr_addr] <= i_wr_data;
      end
    end
  end

  // Next-state and counter logic. cnt tracks the index presented in the
  // following cycle and parks on len-1 once the stream ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_STREAM;
          cnt_d   = '0;
          len_d   = i_len;
        end
      end
      S_STREAM: begin
        if (last_elem) begin
          state_d = (FLUSH == 0) ? S_DONE : S_FLUSH;
          fcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_FLUSH: begin
        if (last_flush) state_d = S_DONE;
        else            fcnt_d  = fcnt_q + FW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-values are decoded from the upcoming state so every output
  // is a flop and matches the state it is presented in.
  always_comb begin
    lane0_d = '0;
    lane1_d = '0;
    valid_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    if (state_d == S_STREAM) begin
      lane0_d = buf0_q[cnt_d];
      lane1_d = buf1_q[cnt_d];
      valid_d = 1'b1;
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_lane0 = lane0_q;
  assign o_lane1 = lane1_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Purpose: directed self-checking bench for systolic_feeder, including a one-cycle skew register on lane1.
// Latency: outputs sampled on the falling edge, inputs driven right after sampling.
// Backpressure: not applicable; every wait is a fixed number of cycles.
module tb_systolic_feeder;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_wr_en = 1'b0;
  logic        i_wr_lane = 1'b0;
  logic [1:0]  i_wr_addr = '0;
  logic [31:0] i_wr_data = '0;
  logic        i_start = 1'b0;
  logic [2:0]  i_len = '0;
  logic        o_busy, o_valid, o_done;
  logic [31:0] o_lane0, o_lane1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] a0 [4];
  logic [31:0] a1 [4];
  logic [31:0] z  [4];

  systolic_feeder #(.DATA_W(32), .DEPTH(4), .FLUSH(3)) dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_wr_en   (i_wr_en),
    .i_wr_lane (i_wr_lane),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_start   (i_start),
    .i_len     (i_len),
    .o_busy    (o_busy),
    .o_valid   (o_valid),
    .o_lane0   (o_lane0),
    .o_lane1   (o_lane1),
    .o_done    (o_done)
  );

  always #5 i_clk = ~i_clk;

  // Downstream skew stage: in1 is lane0 directly, in2 is lane1 delayed a cycle.
  logic [31:0] skew_in1;
  logic [31:0] skew_in2;
  assign skew_in1 = o_lane0;
  always @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) skew_in2 <= '0;
    else         skew_in2 <= o_lane1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic busy_exp);
    chk({tag, "_busy"},  32'(o_busy),  32'(busy_exp));
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_lane0"}, o_lane0,      32'd0);
    chk({tag, "_lane1"}, o_lane1,      32'd0);
    chk({tag, "_done"},  32'(o_done),  32'd0);
  endtask

  // Launches a sequence and checks every cycle of it up to the first idle cycle.
  task automatic run(input int len, input logic [31:0] e0 [4], input logic [31:0] e1 [4],
                     input bit hold, input string tag);
    i_start = 1'b1;
    i_len   = 3'(len);
    @(negedge i_clk);
    i_wr_en = 1'b0;
    if (!hold) i_start = 1'b0;
    for (int k = 0; k < len; k++) begin
      chk({tag, "_valid"}, 32'(o_valid), 32'd1);
      chk({tag, "_busy"},  32'(o_busy),  32'd1);
      chk({tag, "_in1"},   skew_in1,     e0[k]);
      chk({tag, "_lane1"}, o_lane1,      e1[k]);
      chk({tag, "_done"},  32'(o_done),  32'd0);
      if (k > 0) chk({tag, "_in2"}, skew_in2, e1[k-1]);
      @(negedge i_clk);
    end
    chk({tag, "_in2_last"}, skew_in2, e1[len-1]);
    for (int f = 0; f < 3; f++) begin
      chk_quiet({tag, "_flush"}, 1'b1);
      @(negedge i_clk);
    end
    chk({tag, "_done_pulse"}, 32'(o_done),  32'd1);
    chk({tag, "_done_busy"},  32'(o_busy),  32'd1);
    chk({tag, "_done_valid"}, 32'(o_valid), 32'd0);
    @(negedge i_clk);
    chk({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(o_done), 32'd0);
  endtask

  task automatic wr(input logic lane, input logic [1:0] addr, input logic [31:0] data);
    i_wr_en   = 1'b1;
    i_wr_lane = lane;
    i_wr_addr = addr;
    i_wr_data = data;
    @(negedge i_clk);
    i_wr_en = 1'b0;
  endtask

  initial begin
    a0 = '{32'd1, 32'd2, 32'd3, 32'd4};
    a1 = '{32'd5, 32'd6, 32'd7, 32'd8};
    z  = '{32'd0, 32'd0, 32'd0, 32'd0};

    // 1. Reset held 3 cycles, then a run over the cleared buffers.
    repeat (3) begin
      @(negedge i_clk);
      chk_quiet("rst", 1'b0);
    end
    i_rstn = 1'b1;
    @(negedge i_clk);
    run(2, z, z, 1'b0, "rst_run");

    // 2. Full-length run.
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, 2'(i), a0[i]);
      wr(1'b1, 2'(i), a1[i]);
    end
    run(4, a0, a1, 1'b0, "basic");

    // 3. len=1 with start held through done, then back-to-back full run.
    run(1, a0, a1, 1'b1, "len1");
    run(4, a0, a1, 1'b0, "b2b");

    // 4. Illegal lengths, start and write while busy.
    i_start = 1'b1;
    i_len   = 3'd0;
    repeat (3) begin
      @(negedge i_clk);
      chk_quiet("len0", 1'b0);
    end
    i_len = 3'd5;
    repeat (3) begin
      @(negedge i_clk);
      chk_quiet("len5", 1'b0);
    end
    i_len = 3'd1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("busy_run_in1", skew_in1, 32'd1);
    @(negedge i_clk);
    i_start   = 1'b1;
    i_len     = 3'd4;
    i_wr_en   = 1'b1;
    i_wr_lane = 1'b0;
    i_wr_addr = 2'd0;
    i_wr_data = 32'hDEAD;
    @(negedge i_clk);
    i_start = 1'b0;
    i_wr_en = 1'b0;
    chk_quiet("busy_flush", 1'b1);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("busy_run_done", 32'(o_done), 32'd1);
    @(negedge i_clk);
    chk_quiet("busy_run_idle", 1'b0);
    @(negedge i_clk);
    chk_quiet("no_queue", 1'b0);
    run(1, a0, a1, 1'b0, "after_dead");

    // 5. Write coincident with an accepted start is dropped.
    i_wr_en   = 1'b1;
    i_wr_lane = 1'b1;
    i_wr_addr = 2'd0;
    i_wr_data = 32'hBEEF;
    run(1, a0, a1, 1'b0, "wr_start");
    run(1, a0, a1, 1'b0, "wr_start_rerun");

    // 6. Reset after the second element is presented.
    i_start = 1'b1;
    i_len   = 3'd4;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("mid_e0", skew_in1, 32'd1);
    @(negedge i_clk);
    chk("mid_e1_lane0", skew_in1, 32'd2);
    chk("mid_e1_lane1", o_lane1,  32'd6);
    i_rstn = 1'b0;
    #1;
    chk_quiet("mid_rst", 1'b0);
    repeat (2) begin
      @(negedge i_clk);
      chk_quiet("mid_rst_hold", 1'b0);
    end
    i_rstn = 1'b1;
    repeat (6) begin
      @(negedge i_clk);
      chk_quiet("mid_rst_nodone", 1'b0);
    end
    run(4, z, z, 1'b0, "cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
